// File: rtl/atr_interface_parser.sv
// ATR byte-stream parser: walks TS/T0/interface/historical/TCK bytes, checks TCK,
// and commits TA1/TC1 only once the whole ATR has been accepted.
module atr_interface_parser #(
  parameter int         MAX_ATR_BYTES   = 33,
  parameter logic [3:0] DEFAULT_FI_CODE = 4'h1,
  parameter logic [3:0] DEFAULT_DI_CODE = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startAtr,
  input  logic [7:0]  dataIn,
  input  logic        dataStrobe,
  output logic [3:0]  fiCode,
  output logic [3:0]  diCode,
  output logic        ta1Present,
  output logic [7:0]  extraGuard,
  output logic        inverseConvention,
  output logic [3:0]  firstProtocol,
  output logic [15:0] protocolMask,
  output logic [3:0]  histCount,
  output logic        atrDone,
  output logic        atrError
);

  localparam int CW = $clog2(MAX_ATR_BYTES + 1);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_TS    = 4'd1;
  localparam logic [3:0] ST_T0    = 4'd2;
  localparam logic [3:0] ST_TA    = 4'd3;
  localparam logic [3:0] ST_TB    = 4'd4;
  localparam logic [3:0] ST_TC    = 4'd5;
  localparam logic [3:0] ST_TD    = 4'd6;
  localparam logic [3:0] ST_HIST  = 4'd7;
  localparam logic [3:0] ST_TCK   = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;
  localparam logic [3:0] ST_ERROR = 4'd10;

  logic [3:0]    state, nxt_state;
  logic [CW-1:0] byteCount, nxt_byteCount;
  logic [3:0]    pend, nxt_pend;
  logic          firstLevel, nxt_firstLevel;
  logic [3:0]    histLeft, nxt_histLeft;
  logic          tckExp, nxt_tckExp;
  logic [7:0]    tckAcc, nxt_tckAcc;
  logic [7:0]    ta1Sh, nxt_ta1Sh;
  logic          ta1Seen, nxt_ta1Seen;
  logic [7:0]    tc1Sh, nxt_tc1Sh;
  logic [3:0]    nxt_fiCode, nxt_diCode, nxt_firstProtocol, nxt_histCount;
  logic          nxt_ta1Present, nxt_inverseConvention;
  logic [7:0]    nxt_extraGuard;
  logic [15:0]   nxt_protocolMask;
  logic          active;

  // Next structural byte given the interface bytes still pending at this level
  function automatic logic [3:0] iface_next(input logic [3:0] p, input logic [3:0] k,
                                            input logic te);
    if (p[0])         return ST_TA;
    else if (p[1])    return ST_TB;
    else if (p[2])    return ST_TC;
    else if (p[3])    return ST_TD;
    else if (k != 0)  return ST_HIST;
    else if (te)      return ST_TCK;
    else              return ST_DONE;
  endfunction

  assign active   = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
  assign atrDone  = (state == ST_DONE);
  assign atrError = (state == ST_ERROR);

  always_comb begin
    nxt_state             = state;
    nxt_byteCount         = byteCount;
    nxt_pend              = pend;
    nxt_firstLevel        = firstLevel;
    nxt_histLeft          = histLeft;
    nxt_tckExp            = tckExp;
    nxt_tckAcc            = tckAcc;
    nxt_ta1Sh             = ta1Sh;
    nxt_ta1Seen           = ta1Seen;
    nxt_tc1Sh             = tc1Sh;
    nxt_fiCode            = fiCode;
    nxt_diCode            = diCode;
    nxt_ta1Present        = ta1Present;
    nxt_extraGuard        = extraGuard;
    nxt_inverseConvention = inverseConvention;
    nxt_firstProtocol     = firstProtocol;
    nxt_protocolMask      = protocolMask;
    nxt_histCount         = histCount;

    if (startAtr) begin
      nxt_state             = ST_TS;
      nxt_byteCount         = '0;
      nxt_pend              = '0;
      nxt_firstLevel        = 1'b1;
      nxt_histLeft          = '0;
      nxt_tckExp            = 1'b0;
      nxt_tckAcc            = '0;
      nxt_ta1Sh             = '0;
      nxt_ta1Seen           = 1'b0;
      nxt_tc1Sh             = '0;
      nxt_fiCode            = DEFAULT_FI_CODE;
      nxt_diCode            = DEFAULT_DI_CODE;
      nxt_ta1Present        = 1'b0;
      nxt_extraGuard        = '0;
      nxt_inverseConvention = 1'b0;
      nxt_firstProtocol     = '0;
      nxt_protocolMask      = '0;
      nxt_histCount         = '0;
    end else if (dataStrobe && active) begin
      if (byteCount == CW'(MAX_ATR_BYTES)) begin
        nxt_state = ST_ERROR;
      end else begin
        nxt_byteCount = byteCount + 1'b1;
        if (state == ST_T0)      nxt_tckAcc = dataIn;
        else if (state != ST_TS) nxt_tckAcc = tckAcc ^ dataIn;
        case (state)
          ST_TS: begin
            if (dataIn == 8'h3B) begin
              nxt_inverseConvention = 1'b0;
              nxt_state             = ST_T0;
            end else if (dataIn == 8'h3F) begin
              nxt_inverseConvention = 1'b1;
              nxt_state             = ST_T0;
            end else begin
              nxt_state = ST_ERROR;
            end
          end
          ST_T0: begin
            nxt_pend      = dataIn[7:4];
            nxt_histCount = dataIn[3:0];
            nxt_histLeft  = dataIn[3:0];
            nxt_state     = iface_next(dataIn[7:4], dataIn[3:0], tckExp);
          end
          ST_TA: begin
            if (firstLevel) begin
              nxt_ta1Sh   = dataIn;
              nxt_ta1Seen = 1'b1;
            end
            nxt_pend  = pend & 4'b1110;
            nxt_state = iface_next(pend & 4'b1110, histLeft, tckExp);
          end
          ST_TB: begin
            nxt_pend  = pend & 4'b1100;
            nxt_state = iface_next(pend & 4'b1100, histLeft, tckExp);
          end
          ST_TC: begin
            if (firstLevel) nxt_tc1Sh = dataIn;
            nxt_pend  = pend & 4'b1000;
            nxt_state = iface_next(pend & 4'b1000, histLeft, tckExp);
          end
          ST_TD: begin
            nxt_protocolMask = protocolMask | (16'd1 << dataIn[3:0]);
            if (dataIn[3:0] != 4'd0) nxt_tckExp = 1'b1;
            if (firstLevel) nxt_firstProtocol = dataIn[3:0];
            nxt_firstLevel = 1'b0;
            nxt_pend       = dataIn[7:4];
            nxt_state      = iface_next(dataIn[7:4], histLeft, nxt_tckExp);
          end
          ST_HIST: begin
            nxt_histLeft = histLeft - 4'd1;
            if (histLeft == 4'd1) nxt_state = tckExp ? ST_TCK : ST_DONE;
          end
          ST_TCK: begin
            nxt_state = ((tckAcc ^ dataIn) == 8'h00) ? ST_DONE : ST_ERROR;
          end
          default: nxt_state = ST_ERROR;
        endcase
      end
    end

    // Commit uses next-cycle shadows so a TA1/TC1 that is itself the final byte is kept
    if (!startAtr && (nxt_state == ST_DONE) && (state != ST_DONE)) begin
      if (nxt_ta1Seen) begin
        nxt_fiCode = nxt_ta1Sh[7:4];
        nxt_diCode = nxt_ta1Sh[3:0];
      end
      nxt_ta1Present = nxt_ta1Seen;
      nxt_extraGuard = nxt_tc1Sh;
      if (nxt_firstLevel) nxt_protocolMask[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      byteCount         <= '0;
      pend              <= '0;
      firstLevel        <= 1'b0;
      histLeft          <= '0;
      tckExp            <= 1'b0;
      tckAcc            <= '0;
      ta1Sh             <= '0;
      ta1Seen           <= 1'b0;
      tc1Sh             <= '0;
      fiCode            <= DEFAULT_FI_CODE;
      diCode            <= DEFAULT_DI_CODE;
      ta1Present        <= 1'b0;
      extraGuard        <= '0;
      inverseConvention <= 1'b0;
      firstProtocol     <= '0;
      protocolMask      <= '0;
      histCount         <= '0;
    end else begin
      state             <= nxt_state;
      byteCount         <= nxt_byteCount;
      pend              <= nxt_pend;
      firstLevel        <= nxt_firstLevel;
      histLeft          <= nxt_histLeft;
      tckExp            <= nxt_tckExp;
      tckAcc            <= nxt_tckAcc;
      ta1Sh             <= nxt_ta1Sh;
      ta1Seen           <= nxt_ta1Seen;
      tc1Sh             <= nxt_tc1Sh;
      fiCode            <= nxt_fiCode;
      diCode            <= nxt_diCode;
      ta1Present        <= nxt_ta1Present;
      extraGuard        <= nxt_extraGuard;
      inverseConvention <= nxt_inverseConvention;
      firstProtocol     <= nxt_firstProtocol;
      protocolMask      <= nxt_protocolMask;
      histCount         <= nxt_histCount;
    end
  end

endmodule

// File: tb/tb_atr_interface_parser.sv
// Bench for atr_interface_parser: directed ATR cases plus random ATRs checked
// against a byte-sequence parser model.
module tb_atr_interface_parser;

  localparam int MAX_BYTES = 33;

  logic        clk = 1'b0;
  logic        reset, startAtr, dataStrobe;
  logic [7:0]  dataIn;
  logic [3:0]  fiCode, diCode, firstProtocol, histCount;
  logic        ta1Present, inverseConvention, atrDone, atrError;
  logic [7:0]  extraGuard;
  logic [15:0] protocolMask;

  int nchk  = 0;
  int npass = 0;

  atr_interface_parser #(.MAX_ATR_BYTES(MAX_BYTES), .DEFAULT_FI_CODE(4'h1),
                         .DEFAULT_DI_CODE(4'h1)) dut (
    .clk(clk), .reset(reset), .startAtr(startAtr), .dataIn(dataIn),
    .dataStrobe(dataStrobe), .fiCode(fiCode), .diCode(diCode),
    .ta1Present(ta1Present), .extraGuard(extraGuard),
    .inverseConvention(inverseConvention), .firstProtocol(firstProtocol),
    .protocolMask(protocolMask), .histCount(histCount),
    .atrDone(atrDone), .atrError(atrError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done, err, ta1p, inv;
    logic [3:0]  fi, di, fp, hc;
    logic [7:0]  eg;
    logic [15:0] pm;
  } exp_t;

  // Pull the next byte; running past MAX_BYTES marks overflow
  function automatic bit fetch(input logic [7:0] q[$], inout int pos, inout bit ovf,
                               output logic [7:0] v);
    v = 8'h00;
    if (pos >= q.size()) return 1'b0;
    if (pos >= MAX_BYTES) begin
      ovf = 1'b1;
      return 1'b0;
    end
    v = q[pos];
    pos++;
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [7:0] q[$]);
    exp_t r;
    int pos = 0;
    bit ovf = 1'b0, first = 1'b1, tck = 1'b0, hasTd, ta1s = 1'b0;
    logic [7:0] v, x, ta1 = 8'h00, tc1 = 8'h00;
    logic [3:0] y, k, t;
    r.done = 0; r.err = 0; r.ta1p = 0; r.inv = 0; r.fi = 4'h1; r.di = 4'h1;
    r.fp = 0; r.hc = 0; r.eg = 0; r.pm = 0;
    if (!fetch(q, pos, ovf, v)) begin r.err = ovf; return r; end
    if (v == 8'h3B) r.inv = 1'b0;
    else if (v == 8'h3F) r.inv = 1'b1;
    else begin r.err = 1'b1; return r; end
    if (!fetch(q, pos, ovf, v)) begin r.err = ovf; return r; end
    y = v[7:4]; k = v[3:0]; x = v; r.hc = k;
    do begin
      hasTd = y[3];
      for (int b = 0; b < 4; b++) begin
        if (y[b]) begin
          if (!fetch(q, pos, ovf, v)) begin r.err = ovf; return r; end
          x ^= v;
          if (b == 0 && first) begin ta1 = v; ta1s = 1'b1; end
          if (b == 2 && first) tc1 = v;
          if (b == 3) begin
            t = v[3:0];
            r.pm = r.pm | (16'd1 << t);
            if (t != 0) tck = 1'b1;
            if (first) r.fp = t;
          end
        end
      end
      if (hasTd) begin y = v[7:4]; first = 1'b0; end
    end while (hasTd);
    if (first) r.pm = r.pm | 16'd1;
    for (int i = 0; i < int'(k); i++) begin
      if (!fetch(q, pos, ovf, v)) begin r.err = ovf; return r; end
      x ^= v;
    end
    if (tck) begin
      if (!fetch(q, pos, ovf, v)) begin r.err = ovf; return r; end
      x ^= v;
      if (x != 8'h00) begin r.err = 1'b1; return r; end
    end
    r.done = 1'b1;
    if (ta1s) begin r.fi = ta1[7:4]; r.di = ta1[3:0]; end
    r.ta1p = ta1s;
    r.eg = tc1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_exp(input string n, input exp_t r);
    chk({n, ".atrDone"}, 32'(atrDone), 32'(r.done));
    chk({n, ".atrError"}, 32'(atrError), 32'(r.err));
    chk({n, ".fiCode"}, 32'(fiCode), 32'(r.fi));
    chk({n, ".diCode"}, 32'(diCode), 32'(r.di));
    chk({n, ".ta1Present"}, 32'(ta1Present), 32'(r.ta1p));
    chk({n, ".extraGuard"}, 32'(extraGuard), 32'(r.eg));
    if (r.done) begin
      chk({n, ".inverseConvention"}, 32'(inverseConvention), 32'(r.inv));
      chk({n, ".firstProtocol"}, 32'(firstProtocol), 32'(r.fp));
      chk({n, ".protocolMask"}, 32'(protocolMask), 32'(r.pm));
      chk({n, ".histCount"}, 32'(histCount), 32'(r.hc));
    end
  endtask

  task automatic chk_reset(input string n);
    chk({n, ".fiCode"}, 32'(fiCode), 32'h1);
    chk({n, ".diCode"}, 32'(diCode), 32'h1);
    chk({n, ".ta1Present"}, 32'(ta1Present), 32'h0);
    chk({n, ".extraGuard"}, 32'(extraGuard), 32'h0);
    chk({n, ".inverseConvention"}, 32'(inverseConvention), 32'h0);
    chk({n, ".firstProtocol"}, 32'(firstProtocol), 32'h0);
    chk({n, ".protocolMask"}, 32'(protocolMask), 32'h0);
    chk({n, ".histCount"}, 32'(histCount), 32'h0);
    chk({n, ".atrDone"}, 32'(atrDone), 32'h0);
    chk({n, ".atrError"}, 32'(atrError), 32'h0);
  endtask

  task automatic start_pulse();
    startAtr = 1'b1;
    @(negedge clk);
    startAtr = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    dataIn = b;
    dataStrobe = 1'b1;
    @(negedge clk);
    dataStrobe = 1'b0;
    dataIn = 8'($urandom);
  endtask

  task automatic run_atr(input logic [7:0] q[$], input bit gaps);
    start_pulse();
    foreach (q[i]) begin
      strobe(q[i]);
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    logic [3:0] y, ny, k, t;
    int lv;
    reset = 1'b1; startAtr = 1'b0; dataStrobe = 1'b0; dataIn = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    @(negedge clk);

    strobe(8'h3B); strobe(8'h00);
    chk_reset("idle_ignore");

    q = '{8'h3B, 8'h00};
    run_atr(q, 1'b0);
    chk_exp("minimal", model(q));
    chk("minimal.pm_const", 32'(protocolMask), 32'h0001);

    q = '{8'h3B, 8'h11, 8'h96, 8'h55};
    run_atr(q, 1'b0);
    chk_exp("ta1_hist", model(q));
    chk("ta1_hist.fi_const", 32'(fiCode), 32'h9);
    chk("ta1_hist.di_const", 32'(diCode), 32'h6);

    q = '{8'h3B, 8'h90, 8'h95, 8'h81, 8'h01, 8'h85};
    run_atr(q, 1'b0);
    chk_exp("tck_ok", model(q));
    chk("tck_ok.fp_const", 32'(firstProtocol), 32'h1);
    chk("tck_ok.pm_const", 32'(protocolMask), 32'h0002);

    q[5] = 8'h84;
    run_atr(q, 1'b0);
    chk_exp("tck_bad", model(q));
    chk("tck_bad.err_const", 32'(atrError), 32'h1);

    q = '{8'h3C};
    run_atr(q, 1'b0);
    chk_exp("bad_ts", model(q));
    q = '{8'h3F, 8'h00};
    run_atr(q, 1'b0);
    chk_exp("inverse", model(q));
    chk("inverse.inv_const", 32'(inverseConvention), 32'h1);

    start_pulse();
    strobe(8'h3B); strobe(8'h11);
    startAtr = 1'b1; dataStrobe = 1'b1; dataIn = 8'h96;
    @(negedge clk);
    startAtr = 1'b0; dataStrobe = 1'b0;
    strobe(8'h3B); strobe(8'h00);
    q = '{8'h3B, 8'h00};
    chk_exp("abort", model(q));

    q = '{8'h3B, 8'h90, 8'h95, 8'h81, 8'h01, 8'h85};
    run_atr(q, 1'b0);
    start_pulse();
    strobe(8'h3B); strobe(8'h11);
    reset = 1'b1;
    #1;
    chk_reset("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    q = '{8'h3B, 8'h80};
    repeat (31) q.push_back(8'h80);
    run_atr(q, 1'b0);
    chk_exp("len33", model(q));
    q.push_back(8'h80);
    strobe(8'h80);
    chk_exp("len34", model(q));
    chk("len34.err_const", 32'(atrError), 32'h1);

    for (int n = 0; n < 60; n++) begin
      q.delete();
      if ($urandom_range(0, 9) == 0) q.push_back(8'($urandom));
      else q.push_back($urandom_range(0, 1) ? 8'h3B : 8'h3F);
      y = 4'($urandom);
      k = 4'($urandom_range(0, 12));
      q.push_back({y, k});
      lv = 0;
      forever begin
        ny = 4'h0;
        for (int b = 0; b < 4; b++) begin
          if (y[b]) begin
            if (b == 3) begin
              lv++;
              ny = 4'($urandom);
              if (lv >= 3) ny[3] = 1'b0;
              t = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
              q.push_back({ny, t});
            end else begin
              q.push_back(8'($urandom));
            end
          end
        end
        if (!y[3]) break;
        y = ny;
      end
      repeat (k) q.push_back(8'($urandom));
      x = 8'h00;
      for (int i = 1; i < q.size(); i++) x ^= q[i];
      if ($urandom_range(0, 9) < 3) x ^= 8'($urandom_range(1, 255));
      q.push_back(x);
      if ($urandom_range(0, 4) == 0) void'(q.pop_back());
      else if ($urandom_range(0, 4) == 0) repeat (3) q.push_back(8'($urandom));
      run_atr(q, 1'b1);
      chk_exp($sformatf("rnd%0d", n), model(q));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
